// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation sequencer: default widths,
// controller state encoding and the multiplier op-count formula.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_EXP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RED_REQ  = 3'd1,
    ST_RED_WAIT = 3'd2,
    ST_SQ_REQ   = 3'd3,
    ST_SQ_WAIT  = 3'd4,
    ST_MU_REQ   = 3'd5,
    ST_MU_WAIT  = 3'd6,
    ST_FIN      = 3'd7
  } state_e;

  // One base reduction, one square per scanned bit, one multiply per set bit.
  function automatic int op_count(input logic [31:0] e, input int exp_w);
    int n;
    n = 1 + exp_w;
    for (int i = 0; i < exp_w && i < 32; i++) begin
      n += int'(e[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/modexp_ctrl_if.sv
// Request/response bus between the exponentiation sequencer (master) and
// the shared modular multiplier (slave).
interface modexp_ctrl_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_n;
  logic             mul_done;
  logic [WIDTH-1:0] mul_out;

  modport master (
    output mul_start, mul_a, mul_b, mul_n,
    input  mul_done, mul_out
  );

  modport slave (
    input  mul_start, mul_a, mul_b, mul_n,
    output mul_done, mul_out
  );

endinterface

// File: rtl/modexp_ctrl.sv
// Square-and-multiply sequencer: computes base^exp mod modn by scheduling an
// external a*b mod n multiplier, scanning exponent bits MSB-first.
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int EXP_W = DEFAULT_EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [WIDTH-1:0] modn_i,
  output logic [WIDTH-1:0] out_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             err_o,
  modexp_ctrl_if.master    mul_if
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             last_bit;

  // NOTE: reset is synchronous, so rst_n is tested inside the edge-triggered
  // block and kept out of the sensitivity list; non-blocking assignments keep
  // every register updating from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      e_q     <= e_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign last_bit = (idx_q == '0);

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    b_d              = b_q;
    e_d              = e_q;
    n_d              = n_q;
    acc_d            = acc_q;
    idx_d            = idx_q;
    out_d            = out_q;
    err_d            = err_q;
    mul_if.mul_start = 1'b0;
    mul_if.mul_a     = '0;
    mul_if.mul_b     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          b_d   = base_i;
          e_d   = exp_i;
          n_d   = modn_i;
          err_d = (modn_i == '0);
          if (modn_i < WIDTH'(2)) begin
            acc_d   = '0;
            state_d = ST_FIN;
          end else begin
            acc_d   = WIDTH'(1);
            idx_d   = IDX_W'(EXP_W - 1);
            state_d = ST_RED_REQ;
          end
        end
      end

      // Operands are also driven in the WAIT states so they stay stable
      // until the multiplier answers.
      ST_RED_REQ, ST_RED_WAIT: begin
        mul_if.mul_start = (state_q == ST_RED_REQ);
        mul_if.mul_a     = b_q;
        mul_if.mul_b     = WIDTH'(1);
        if (state_q == ST_RED_REQ) begin
          state_d = ST_RED_WAIT;
        end else if (mul_if.mul_done) begin
          b_d     = mul_if.mul_out;
          state_d = ST_SQ_REQ;
        end
      end

      ST_SQ_REQ, ST_SQ_WAIT: begin
        mul_if.mul_start = (state_q == ST_SQ_REQ);
        mul_if.mul_a     = acc_q;
        mul_if.mul_b     = acc_q;
        if (state_q == ST_SQ_REQ) begin
          state_d = ST_SQ_WAIT;
        end else if (mul_if.mul_done) begin
          acc_d = mul_if.mul_out;
          if (e_q[idx_q]) begin
            state_d = ST_MU_REQ;
          end else begin
            state_d = last_bit ? ST_FIN : ST_SQ_REQ;
            if (!last_bit) idx_d = idx_q - 1'b1;
          end
        end
      end

      ST_MU_REQ, ST_MU_WAIT: begin
        mul_if.mul_start = (state_q == ST_MU_REQ);
        mul_if.mul_a     = acc_q;
        mul_if.mul_b     = b_q;
        if (state_q == ST_MU_REQ) begin
          state_d = ST_MU_WAIT;
        end else if (mul_if.mul_done) begin
          acc_d   = mul_if.mul_out;
          state_d = last_bit ? ST_FIN : ST_SQ_REQ;
          if (!last_bit) idx_d = idx_q - 1'b1;
        end
      end

      ST_FIN: begin
        out_d   = acc_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mul_if.mul_n = n_q;
  assign done_o       = (state_q == ST_FIN);
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;
  // The result is presented alongside done, then held in out_q.
  assign out_o        = (state_q == ST_FIN) ? acc_q : out_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: behavioural multiplier with variable
// latency, a repeated-multiplication reference model and a per-cycle checker.
module tb_modexp_ctrl;
  import rsa_pkg::*;

  localparam int WIDTH = 8;
  localparam int EXP_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [WIDTH-1:0] base_i;
  logic [EXP_W-1:0] exp_i;
  logic [WIDTH-1:0] modn_i;
  logic [WIDTH-1:0] out_o;
  logic             done_o;
  logic             busy_o;
  logic             err_o;

  modexp_ctrl_if #(.WIDTH(WIDTH)) mif ();

  modexp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .base_i  (base_i),
    .exp_i   (exp_i),
    .modn_i  (modn_i),
    .out_o   (out_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .err_o   (err_o),
    .mul_if  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain repeated multiplication, no square-and-multiply.
  function automatic int model_exp(input int b, input int e, input int n);
    int r;
    if (n < 2) return 0;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return r;
  endfunction

  // Shared state between model, multiplier and stimulus.
  bit   armed     = 0;
  int   fixed_l   = 1;
  bit   mul_abort = 0;
  bit   spur_req  = 0;
  int   ops       = 0;
  int   lat_sum   = 0;
  int   first_a   = -1;
  int   first_b   = -1;
  bit   m_busy    = 0;
  bit   m_err     = 0;
  int   m_held    = 0;
  int   m_out     = 0;
  int   m_n       = 0;
  int   start_cyc = 0;

  // Behavioural mod_mul: latency fixed_l, or random 1..6 per op when 0.
  initial begin
    mif.mul_done = 1'b0;
    mif.mul_out  = '0;
    forever begin
      int lat;
      int a, b, n;
      @(posedge clk); #1;
      mif.mul_done = 1'b0;
      if (armed && mif.mul_start === 1'b1) begin
        a = int'(mif.mul_a);
        b = int'(mif.mul_b);
        n = int'(mif.mul_n);
        if (ops == 0) begin
          first_a = a;
          first_b = b;
        end
        ops++;
        lat = (fixed_l > 0) ? fixed_l : int'($urandom_range(1, 6));
        lat_sum += lat + 1;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
          if (!mul_abort) begin
            check("mul_a_stable", mif.mul_a, a);
            check("mul_b_stable", mif.mul_b, b);
            check("mul_n_stable", mif.mul_n, n);
            check("mul_start_one_cycle", mif.mul_start, 0);
          end
        end
        mif.mul_done = 1'b1;
        mif.mul_out  = (n == 0) ? '0 : WIDTH'((a * b) % n);
      end else if (spur_req) begin
        mif.mul_done = 1'b1;
        mif.mul_out  = WIDTH'($urandom);
        spur_req     = 0;
      end
    end
  end

  // Per-cycle compare against the model; model state then steps one cycle.
  always @(negedge clk) begin
    bit exp_done;
    if (armed) begin
      exp_done = m_busy && (ops == m_n) && (cyc == start_cyc + 1 + lat_sum);
      check("done", done_o, exp_done);
      check("busy", busy_o, m_busy);
      check("err", err_o, m_err);
      check("out", out_o, exp_done ? m_out : m_held);
      if (!m_busy) check("mul_start_idle", mif.mul_start, 0);
      if (m_busy && ops > m_n) check("op_overrun", ops, m_n);
      if (!rst_n) begin
        m_busy = 0;
        m_err  = 0;
        m_held = 0;
      end else if (exp_done) begin
        m_busy = 0;
        m_held = m_out;
      end else if (!m_busy && start_i) begin
        m_busy    = 1;
        start_cyc = cyc;
        ops       = 0;
        lat_sum   = 0;
        first_a   = -1;
        first_b   = -1;
        m_err     = (modn_i == '0);
        m_out     = model_exp(int'(base_i), int'(exp_i), int'(modn_i));
        m_n       = (modn_i < 2) ? 0 : op_count(32'(exp_i), EXP_W);
      end
    end
  end

  task automatic run_op(input int b, input int e, input int n, input int lat, input int poke,
                        output int dcyc, output int dout, output int derr);
    fixed_l = lat;
    @(posedge clk); #1;
    start_i = 1'b1;
    base_i  = WIDTH'(b);
    exp_i   = EXP_W'(e);
    modn_i  = WIDTH'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
    base_i  = WIDTH'($urandom);
    exp_i   = EXP_W'($urandom);
    modn_i  = WIDTH'($urandom);
    dcyc = -1;
    dout = -1;
    derr = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done_o === 1'b1) begin
        dcyc = cyc - start_cyc;
        dout = int'(out_o);
        derr = int'(err_o);
        break;
      end
      start_i = (k == poke);
      if (k == poke) begin
        base_i = WIDTH'($urandom);
        exp_i  = EXP_W'($urandom);
        modn_i = WIDTH'($urandom_range(2, 255));
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    check("done_within_budget", dcyc >= 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int dc, dout, derr;
    rst_n   = 1'b0;
    start_i = 1'b0;
    base_i  = '0;
    exp_i   = '0;
    modn_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    armed = 1;
    check("reset_out", out_o, 0);
    check("reset_done", done_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_mul_start", mif.mul_start, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model and the op-count helper to hand-computed values.
    check("model_88_7_187", model_exp(88, 7, 187), 11);
    check("model_11_23_187", model_exp(11, 23, 187), 88);
    check("opcount_7", op_count(32'd7, EXP_W), 12);
    check("opcount_23", op_count(32'd23, EXP_W), 13);

    run_op(88, 7, 187, 1, -1, dc, dout, derr);
    check("enc_out", dout, 11);
    check("enc_err", derr, 0);
    check("enc_cycle", dc, 25);
    check("enc_ops", ops, 12);

    run_op(11, 23, 187, 3, -1, dc, dout, derr);
    check("dec_out", dout, 88);
    check("dec_cycle", dc, 53);
    check("dec_ops", ops, 13);

    run_op(10, 3, 7, 2, -1, dc, dout, derr);
    check("red_out", dout, 6);
    check("red_first_a", first_a, 10);
    check("red_first_b", first_b, 1);

    run_op(3, 5, 7, 0, -1, dc, dout, derr);
    check("small_out", dout, 5);

    run_op(5, 0, 11, 2, -1, dc, dout, derr);
    check("exp0_out", dout, 1);

    run_op(9, 5, 1, 1, -1, dc, dout, derr);
    check("mod1_out", dout, 0);
    check("mod1_err", derr, 0);
    check("mod1_cycle", dc, 1);

    run_op(9, 5, 0, 1, -1, dc, dout, derr);
    check("mod0_out", dout, 0);
    check("mod0_err", derr, 1);
    check("mod0_cycle", dc, 1);
    check("mod0_ops", ops, 0);

    spur_req = 1;
    repeat (4) @(posedge clk);
    #1;

    run_op(88, 7, 187, 0, 7, dc, dout, derr);
    check("poke_out", dout, 11);

    // Reset during SQ_WAIT of the first square (RED op cycles 1..6, SQ req 7).
    fixed_l = 5;
    @(posedge clk); #1;
    start_i = 1'b1;
    base_i  = 8'd88;
    exp_i   = 8'd7;
    modn_i  = 8'd187;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    mul_abort = 1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", busy_o, 0);
    check("rst_mul_start", mif.mul_start, 0);
    check("rst_done", done_o, 0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    mul_abort = 0;
    run_op(88, 7, 187, 2, -1, dc, dout, derr);
    check("post_rst_out", dout, 11);

    for (int i = 0; i < 25; i++) begin
      int b, e, n, p;
      b = int'($urandom_range(0, 255));
      e = int'($urandom_range(0, 255));
      n = (i % 6 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 255));
      p = (i % 3 == 0) ? int'($urandom_range(0, 40)) : -1;
      run_op(b, e, n, 0, p, dc, dout, derr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
